mac_pair_acc: RTL
=================

# mac_pair_acc

Dual signed 8×8 multiply-accumulate stage sitting directly upstream of the PISO output serializer. It consumes a stream of activation bytes, each paired with two weight bytes, over a programmed run length. It accumulates two 16-bit saturating dot products and presents them as `mac0_out` / `mac1_out`. A one-cycle `DONE` pulse marks the point where both results are final and may be loaded into the serializer.

## Interface
- `LEN_W`, default 8: width of the run-length input and the beat counter.
- `CLKEXT` in 1: clock, rising edge.
- `RST_GLO` in 1: reset, asynchronous, active-high.
- `CLR_MAC` in 1: synchronous clear of accumulators, counter, flags and FSM (to IDLE).
- `START` in 1: begins a run; sampled only in IDLE.
- `LEN` in `LEN_W`: number of beats in the run; latched on accepted `START`.
- `VALID_IN` in 1: `D_IN`/`W0`/`W1` valid this cycle.
- `D_IN` in 8: signed activation (two's complement).
- `W0` in 8: signed weight for lane 0.
- `W1` in 8: signed weight for lane 1.
- `READY_IN` out 1: high in RUN; a beat is accepted when `VALID_IN & READY_IN`.
- `BUSY` out 1: high in RUN and DONE states.
- `DONE` out 1: one-cycle pulse; results final.
- `SAT` out 2: sticky saturation flags; bit0 = lane 0, bit1 = lane 1.
- `mac0_out` out 16: lane 0 accumulator, signed, registered.
- `mac1_out` out 16: lane 1 accumulator, signed, registered.

## Operation
- **Priority:** `RST_GLO` > `CLR_MAC` > FSM.
- **Reset / CLR values:** state IDLE, `mac0_out`/`mac1_out` = 0, `SAT` = 0, `DONE` = 0, `READY_IN` = 0, `BUSY` = 0, counter = 0, latched length = 0.
- **IDLE**
  - `START`=1: accumulators := 0, `SAT` := 0, counter := 0, length := `LEN`.
  - Next state is RUN, or DONE if `LEN` == 0.
  - `START`=0: hold; outputs keep the last results.
- **RUN**
  - `READY_IN`=1.
  - On an accepted beat:
    - `acc0 := sat16(acc0 + D_IN*W0)`
    - `acc1 := sat16(acc1 + D_IN*W1)`
    - counter++
  - If the accepted beat is beat `length-1`, next state is DONE.
  - `VALID_IN`=0 stalls with no change; there is no timeout.
  - `START` is ignored.
- **DONE:** `DONE`=1 for exactly one cycle, `READY_IN`=0, then IDLE. `START` is ignored in this state.
- **Arithmetic**
  - Each product is a full signed 16-bit value: range −16256 … +16384 (−128 × −128 = +16384).
  - The sum is formed at 17 bits.
  - If the sum is > 32767, the result is 32767; if it is < −32768, the result is −32768. In either case the lane's `SAT` bit is set.
  - The accumulator keeps operating from the clamped value.
  - `SAT` is sticky until the next accepted `START`, `CLR_MAC` or reset.
- **Results:** `mac*_out` hold their value after DONE until the next accepted `START`, `CLR_MAC` or reset. This lets the serializer load them any number of cycles later.
- **`CLR_MAC` mid-run:** run aborted, all state cleared next edge, no `DONE` pulse.
- **`RST_GLO` mid-run:** immediate asynchronous clear to the reset values.

## Timing
- Accumulator latency: beat accepted at edge *n* → `mac*_out` updated at edge *n*.
  - The value is visible during cycle *n+1*.
- `DONE` rises at the same edge as the last accumulator update.
  - The final `mac*_out` is therefore valid in the `DONE` cycle.
- `START` accepted at edge *s*:
  - `READY_IN` high from edge *s*.
  - `mac*_out` reads 0 from edge *s*.
- Throughput: one beat per cycle. A run of L beats with `VALID_IN` held high takes L+1 cycles from `START` to the `DONE` cycle, inclusive of the DONE cycle.
- `LEN`=0: `DONE` pulses the cycle after `START` with outputs = 0.
- `LEN` = 2^`LEN_W` − 1 (255): counter must not wrap before completion.

## Test plan
- **Basic run:** reset, then `START` with `LEN`=3 and beats (D,W0,W1) = (2,3,−1), (−4,5,2), (10,1,1), with `VALID_IN` held high.
  - `mac0_out` = 6, −14, −4 at successive edges; `mac1_out` = −2, −10, 0.
  - `DONE` pulses in the third result cycle; `READY_IN` drops.
- **Stall:** `LEN`=2, with `VALID_IN` low for 5 cycles between the beats (1,1,1) and (1,1,1).
  - Outputs hold at 1 during the stall.
  - Final `mac0_out` = `mac1_out` = 2; `DONE` arrives exactly one cycle after the second beat is accepted.
- **Saturation:** `LEN`=3, beats (−128,−128,127) ×3.
  - `mac0_out` = 16384, then 32767 with `SAT[0]`=1, then stays 32767.
  - `mac1_out` = −16256, −32512, then −32768 with `SAT[1]`=1.
  - The next `START` clears `SAT` to 0.
- **`LEN`=0:** `START` gives `DONE`=1 in the next cycle; `mac*_out` = 0, `SAT` = 0.
- **Abort:**
  - Assert `CLR_MAC` after 2 of 4 beats: outputs are 0, state IDLE, and no `DONE` pulse.
  - Assert `RST_GLO` asynchronously mid-run: outputs are 0 immediately, without waiting for a clock edge.
- **Ignored `START`:** pulse `START` during RUN with `LEN`=4 → the run completes with the original length and the accumulators are not cleared.

Source files
------------

// File: rtl/mac_pair_acc_if.sv
// Beat, control and result bundle between the activation source, the dual MAC
// stage and the downstream serializer.
interface mac_pair_acc_if #(
  parameter int LEN_W = 8
);
  logic             START;
  logic [LEN_W-1:0] LEN;
  logic             VALID_IN;
  logic [7:0]       D_IN;
  logic [7:0]       W0;
  logic [7:0]       W1;
  logic             READY_IN;
  logic             BUSY;
  logic             DONE;
  logic [1:0]       SAT;
  logic [15:0]      mac0_out;
  logic [15:0]      mac1_out;

  // Handshake: a beat (D_IN/W0/W1) transfers on a rising edge where
  // VALID_IN & READY_IN; the source may hold VALID_IN low to stall indefinitely.
  modport master (
    output START, LEN, VALID_IN, D_IN, W0, W1,
    input  READY_IN, BUSY, DONE, SAT, mac0_out, mac1_out
  );
  modport slave (
    input  START, LEN, VALID_IN, D_IN, W0, W1,
    output READY_IN, BUSY, DONE, SAT, mac0_out, mac1_out
  );
endinterface

// File: rtl/mac_pair_acc.sv
// Dual signed 8x8 MAC with 16-bit saturating accumulators over a programmed
// run length; DONE pulses once when both results are final.
module mac_pair_acc #(
  parameter int LEN_W = 8
) (
  input  logic        CLKEXT,
  input  logic        RST_GLO,
  input  logic        CLR_MAC,
  mac_pair_acc_if.slave bus,
  output logic [1:0]  state_o
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [15:0]      acc0_q, acc0_d, acc1_q, acc1_d;
  logic [1:0]       sat_q, sat_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;

  logic signed [15:0] prod0, prod1;
  logic [16:0]        add0, add1;
  logic               beat;

  // Returns {overflow, clamped sum}; the sum is formed at 17 bits.
  function automatic logic [16:0] sat_add(input logic [15:0] acc, input logic [15:0] prod);
    logic [16:0] sum;
    sum = {acc[15], acc} + {prod[15], prod};
    case (sum[16:15])
      2'b01:   sat_add = {1'b1, 16'h7FFF};
      2'b10:   sat_add = {1'b1, 16'h8000};
      default: sat_add = {1'b0, sum[15:0]};
    endcase
  endfunction

  assign prod0 = $signed(bus.D_IN) * $signed(bus.W0);
  assign prod1 = $signed(bus.D_IN) * $signed(bus.W1);
  assign add0  = sat_add(acc0_q, prod0);
  assign add1  = sat_add(acc1_q, prod1);
  assign beat  = (state_q == S_RUN) && bus.VALID_IN;

  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      state_q <= S_IDLE;
      acc0_q  <= '0;
      acc1_q  <= '0;
      sat_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (CLR_MAC) begin
      state_d = S_IDLE;
      acc0_d  = '0;
      acc1_d  = '0;
      sat_d   = '0;
      cnt_d   = '0;
      len_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            acc0_d  = '0;
            acc1_d  = '0;
            sat_d   = '0;
            cnt_d   = '0;
            len_d   = bus.LEN;
            state_d = (bus.LEN == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (beat) begin
            acc0_d = add0[15:0];
            acc1_d = add1[15:0];
            sat_d  = sat_q | {add1[16], add0[16]};
            cnt_d  = cnt_q + 1'b1;
            // Compare against length-1 so a full-scale length never needs the counter to wrap.
            if (cnt_q == len_q - 1'b1) state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.READY_IN = (state_q == S_RUN);
  assign bus.BUSY     = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.DONE     = (state_q == S_DONE);
  assign bus.SAT      = sat_q;
  assign bus.mac0_out = acc0_q;
  assign bus.mac1_out = acc1_q;
  assign state_o      = state_q;
endmodule
